// File: rtl/fp_normaliser_pipe_if.sv
// Stream interface for the post-add normaliser: raw sum in, normalised result out.
// The master modport is the producer/consumer side; the slave modport is the normaliser.
interface fp_normaliser_pipe_if #(
    parameter int unsigned EW = 8,
    parameter int unsigned MW = 23
) ();
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] in_e;
    logic [MW+1:0] in_m;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_e;
    logic [MW+1:0] out_m;
    logic          out_zero;
    logic          out_ovf;
    logic          out_unf;

    modport master (
        output in_valid, in_e, in_m, out_ready,
        input  in_ready, out_valid, out_e, out_m, out_zero, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_e, in_m, out_ready,
        output in_ready, out_valid, out_e, out_m, out_zero, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_normaliser_pipe.sv
// Two-stage post-add normaliser. S1 registers the input, its class and the leading-zero count;
// S2 registers the shifted result. Optional macro FP_NORM_DENORM_EN keeps denormals on underflow.
module fp_normaliser_pipe #(
    parameter int unsigned EW = 8,
    parameter int unsigned MW = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    fp_normaliser_pipe_if.slave  bus
);
    localparam int unsigned ML = MW + 2;
    localparam int unsigned KW = $clog2(MW + 1);
    localparam logic [EW:0] E_INF = {1'b0, {EW{1'b1}}};

    typedef enum logic [1:0] {
        CLS_CARRY,
        CLS_NORM,
        CLS_ZERO,
        CLS_LEFT
    } cls_t;

    logic          s1_valid;
    logic [EW-1:0] s1_e;
    logic [ML-1:0] s1_m;
    cls_t          s1_cls;
    logic [KW-1:0] s1_k;

    logic          s2_load;
    cls_t          in_cls;
    logic [KW-1:0] in_k;

    logic [EW:0]   e_ext;
    logic [EW:0]   e_inc;
    logic [EW-1:0] nx_e;
    logic [ML-1:0] nx_m;
    logic          nx_zero;
    logic          nx_ovf;
    logic          nx_unf;
`ifdef FP_NORM_DENORM_EN
    logic [EW-1:0] den_s;
    logic [ML-1:0] den_m;
`endif

    assign s2_load     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_load;

    // Classification and leading-zero count over hidden bit + fraction
    always_comb begin
        in_k = '0;
        for (int i = 0; i <= int'(MW); i++) begin
            if (bus.in_m[i]) begin
                in_k = KW'(int'(MW) - i);
            end
        end
        if (bus.in_m[ML-1]) begin
            in_cls = CLS_CARRY;
        end else if (bus.in_m[MW]) begin
            in_cls = CLS_NORM;
        end else if (bus.in_m == '0) begin
            in_cls = CLS_ZERO;
        end else begin
            in_cls = CLS_LEFT;
        end
    end

    // Shift and exponent adjust; exponent math is one bit wider so it never wraps
    always_comb begin
        e_ext   = {1'b0, s1_e};
        e_inc   = e_ext + (EW+1)'(1);
        nx_e    = s1_e;
        nx_m    = s1_m;
        nx_zero = 1'b0;
        nx_ovf  = 1'b0;
        nx_unf  = 1'b0;
`ifdef FP_NORM_DENORM_EN
        den_s   = (s1_e == '0) ? '0 : s1_e - EW'(1);
        den_m   = s1_m << den_s;
`endif
        case (s1_cls)
            CLS_CARRY: begin
                if (e_inc >= E_INF) begin
                    nx_e   = '1;
                    nx_m   = '0;
                    nx_ovf = 1'b1;
                end else begin
                    nx_e = EW'(e_inc);
                    nx_m = s1_m >> 1;
                end
            end
            CLS_ZERO: begin
                nx_e    = '0;
                nx_m    = '0;
                nx_zero = 1'b1;
            end
            CLS_LEFT: begin
                if (e_ext <= (EW+1)'(s1_k)) begin
                    nx_e   = '0;
                    nx_unf = 1'b1;
`ifdef FP_NORM_DENORM_EN
                    nx_m    = den_m;
                    nx_zero = (den_m == '0);
`else
                    nx_m    = '0;
                    nx_zero = 1'b1;
`endif
                end else begin
                    nx_e = EW'(e_ext - (EW+1)'(s1_k));
                    nx_m = s1_m << s1_k;
                end
            end
            default: begin
                nx_e = s1_e;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_e          <= '0;
            s1_m          <= '0;
            s1_cls        <= CLS_NORM;
            s1_k          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_e     <= '0;
            bus.out_m     <= '0;
            bus.out_zero  <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_unf   <= 1'b0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_e   <= bus.in_e;
                    s1_m   <= bus.in_m;
                    s1_cls <= in_cls;
                    s1_k   <= in_k;
                end
            end
            if (s2_load) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_e    <= nx_e;
                    bus.out_m    <= nx_m;
                    bus.out_zero <= nx_zero;
                    bus.out_ovf  <= nx_ovf;
                    bus.out_unf  <= nx_unf;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_normaliser_pipe.sv
// Self-checking bench for fp_normaliser_pipe: directed vector table, stall/reset sequences
// and a randomized stream scored against an arithmetic reference model.
module tb_fp_normaliser_pipe;
    localparam int unsigned EW = 8;
    localparam int unsigned MW = 23;
    localparam int unsigned ML = MW + 2;

    typedef struct {
        logic [EW-1:0] e;
        logic [ML-1:0] m;
        logic          zero;
        logic          ovf;
        logic          unf;
    } res_t;

    typedef struct {
        logic [EW-1:0] in_e;
        logic [ML-1:0] in_m;
        res_t          exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_normaliser_pipe_if #(.EW(EW), .MW(MW)) bus ();
    fp_normaliser_pipe #(.EW(EW), .MW(MW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int   checks = 0;
    int   failures = 0;
    res_t sb[$];
    logic stalled_prev = 1'b0;
    res_t held;
    logic sampled_in_ready;
    int   out_count = 0;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [EW+ML+2:0] pk(input res_t r);
        return {r.e, r.m, r.zero, r.ovf, r.unf};
    endfunction

    function automatic res_t dut_out();
        res_t r;
        r.e = bus.out_e; r.m = bus.out_m;
        r.zero = bus.out_zero; r.ovf = bus.out_ovf; r.unf = bus.out_unf;
        return r;
    endfunction

    // Reference: classify by magnitude, normalise by repeated doubling
    function automatic res_t model(input logic [EW-1:0] e, input logic [ML-1:0] m);
        res_t   r;
        int     ei;
        int     k;
        longint mm;
        r.e = e; r.m = m; r.zero = 1'b0; r.ovf = 1'b0; r.unf = 1'b0;
        ei = int'(e);
        mm = longint'(m);
        if (mm >= (longint'(1) << (MW + 1))) begin
            if (ei + 1 >= (1 << EW) - 1) begin
                r.e = '1; r.m = '0; r.ovf = 1'b1;
            end else begin
                r.e = EW'(ei + 1); r.m = ML'(mm / 2);
            end
        end else if (mm >= (longint'(1) << MW)) begin
            r.m = m;
        end else if (mm == 0) begin
            r.e = '0; r.m = '0; r.zero = 1'b1;
        end else begin
            k = 0;
            while (mm < (longint'(1) << MW)) begin
                mm = mm * 2;
                k++;
            end
            if (ei <= k) begin
                r.e = '0; r.unf = 1'b1;
`ifdef FP_NORM_DENORM_EN
                r.m = ML'(longint'(m) * (longint'(1) << ((ei == 0) ? 0 : ei - 1)));
                r.zero = (r.m == '0);
`else
                r.m = '0; r.zero = 1'b1;
`endif
            end else begin
                r.e = EW'(ei - k); r.m = ML'(mm);
            end
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [EW-1:0] ie, input logic [ML-1:0] im,
                                input logic [EW-1:0] oe, input logic [ML-1:0] om,
                                input logic z, input logic o, input logic u);
        vec_t v;
        v.in_e = ie; v.in_m = im;
        v.exp.e = oe; v.exp.m = om; v.exp.zero = z; v.exp.ovf = o; v.exp.unf = u;
        return v;
    endfunction

    // One cycle: sample handshakes at negedge, score outputs, return just after the next posedge
    task automatic step(output logic in_fire);
        res_t ex;
        @(negedge clk);
        if (stalled_prev) begin
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_hold", 64'(pk(dut_out())), 64'(pk(held)));
        end
        sampled_in_ready = bus.in_ready;
        in_fire = bus.in_valid && bus.in_ready;
        if (in_fire) sb.push_back(model(bus.in_e, bus.in_m));
        if (bus.out_valid && bus.out_ready) begin
            out_count++;
            if (sb.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                ex = sb.pop_front();
                check("stream_out", 64'(pk(dut_out())), 64'(pk(ex)));
            end
        end
        stalled_prev = bus.out_valid && !bus.out_ready;
        held = dut_out();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ML-1:0] rand_m();
        int unsigned p;
        case ($urandom_range(0, 3))
            0: return {1'b1, 24'($urandom)};
            1: return {2'b01, 23'($urandom)};
            2: return '0;
            default: begin
                p = $urandom_range(0, 22);
                return ML'((longint'(1) << p) | (longint'($urandom) & ((longint'(1) << p) - 1)));
            end
        endcase
    endfunction

    vec_t tv[11];
    logic fired;
    logic saw_block;
    int   idx;
    int   cyc;

    initial begin
        bus.in_valid = 1'b0; bus.in_e = '0; bus.in_m = '0; bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 64'({bus.out_valid, pk(dut_out())}), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;

        tv[0]  = mk(8'h80, 25'h0800000, 8'h80, 25'h0800000, 1'b0, 1'b0, 1'b0);
        tv[1]  = mk(8'h80, 25'h1000001, 8'h81, 25'h0800000, 1'b0, 1'b0, 1'b0);
        tv[2]  = mk(8'hFE, 25'h1800000, 8'hFF, 25'h0000000, 1'b0, 1'b1, 1'b0);
        tv[3]  = mk(8'h80, 25'h0000010, 8'h6D, 25'h0800000, 1'b0, 1'b0, 1'b0);
        tv[4]  = mk(8'h55, 25'h0000000, 8'h00, 25'h0000000, 1'b1, 1'b0, 1'b0);
        tv[6]  = mk(8'hFD, 25'h1FFFFFF, 8'hFE, 25'h0FFFFFF, 1'b0, 1'b0, 1'b0);
        tv[7]  = mk(8'h18, 25'h0000001, 8'h01, 25'h0800000, 1'b0, 1'b0, 1'b0);
        tv[9]  = mk(8'hFF, 25'h0C00000, 8'hFF, 25'h0C00000, 1'b0, 1'b0, 1'b0);
`ifdef FP_NORM_DENORM_EN
        tv[5]  = mk(8'h05, 25'h0000100, 8'h00, 25'h0001000, 1'b0, 1'b0, 1'b1);
        tv[8]  = mk(8'h17, 25'h0000001, 8'h00, 25'h0400000, 1'b0, 1'b0, 1'b1);
        tv[10] = mk(8'h00, 25'h0400000, 8'h00, 25'h0400000, 1'b0, 1'b0, 1'b1);
`else
        tv[5]  = mk(8'h05, 25'h0000100, 8'h00, 25'h0000000, 1'b1, 1'b0, 1'b1);
        tv[8]  = mk(8'h17, 25'h0000001, 8'h00, 25'h0000000, 1'b1, 1'b0, 1'b1);
        tv[10] = mk(8'h00, 25'h0400000, 8'h00, 25'h0000000, 1'b1, 1'b0, 1'b1);
`endif

        // Directed vectors with exact two-cycle latency
        for (int i = 0; i < 11; i++) begin
            bus.in_e = tv[i].in_e; bus.in_m = tv[i].in_m;
            bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_early", i), 64'(bus.out_valid), 64'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("vec%0d_data", i), 64'(pk(dut_out())), 64'(pk(tv[i].exp)));
            @(posedge clk); #1;
        end

        // Back-to-back stream of 6 with a downstream stall in cycles 3-5
        saw_block = 1'b0;
        out_count = 0;
        idx = 0;
        cyc = 1;
        while (idx < 6 && cyc < 40) begin
            bus.in_e = tv[idx].in_e; bus.in_m = tv[idx].in_m;
            bus.in_valid = 1'b1;
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            step(fired);
            if (!sampled_in_ready) saw_block = 1'b1;
            if (fired) idx++;
            cyc++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step(fired);
        check("s5_all_accepted", 64'(idx), 64'd6);
        check("s5_in_ready_drop", 64'(saw_block), 64'd1);
        check("s5_out_count", 64'(out_count), 64'd6);
        check("s5_drain_empty", 64'(sb.size()), 64'd0);

        // Randomized stream with random backpressure
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_e = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
            bus.in_m = rand_m();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step(fired);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step(fired);
        check("rand_drain_empty", 64'(sb.size()), 64'd0);

        // Reset with two items in flight
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_e = 8'h80; bus.in_m = 25'h0800000;
        step(fired);
        bus.in_e = 8'h81; bus.in_m = 25'h1000000;
        step(fired);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        stalled_prev = 1'b0;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_idle", 64'(bus.out_valid), 64'd0);
        end
        bus.in_valid = 1'b1; bus.in_e = 8'h80; bus.in_m = 25'h0000010;
        step(fired);
        bus.in_valid = 1'b0;
        out_count = 0;
        for (int i = 0; i < 5; i++) step(fired);
        check("post_rst_count", 64'(out_count), 64'd1);
        check("post_rst_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
